// File: rtl/pu_io_initiator.sv
// pu_io_initiator: turns a single core access into one io_req pulse to a memory
// responder, waits for io_ack (or an ack timeout) and returns a one-cycle response.
// Only one access is ever outstanding.
//
// Ports
//   clk, rstn        : clock, asynchronous active-low reset
//   core_req/rdy     : core request, accepted when core_rdy is high (IDLE only)
//   core_cmd         : access descriptor (addr, tid, wr, atomic, funct5, wdata)
//   core_rsp         : one-cycle response strobe
//   core_rsp_data    : load / atomic old value, zero for pure stores and timeouts
//   core_rsp_err     : response ended by ack timeout
//   io_req           : one-cycle request pulse to the responder
//   io_cmd           : command, held from io_req until the next accepted request
//   io_ack/ack_data  : responder completion strobe and its data

package pu_io_pkg;

  localparam int unsigned PU_WIDTH_NBITS  = 32;
  localparam int unsigned PU_ADDR_NBITS   = 32;
  localparam int unsigned PU_TID_NBITS    = 8;
  localparam int unsigned PU_FUNCT5_NBITS = 5;

  // Access descriptor carried unmodified from core to responder
  typedef struct packed {
    logic [PU_ADDR_NBITS-1:0]   addr;
    logic [PU_TID_NBITS-1:0]    tid;
    logic                       wr;
    logic                       atomic;
    logic [PU_FUNCT5_NBITS-1:0] funct5;
    logic [PU_WIDTH_NBITS-1:0]  wdata;
  } io_type;

endpackage

module pu_io_initiator
  import pu_io_pkg::*;
#(
  parameter int unsigned WIDTH_NBITS   = PU_WIDTH_NBITS,
  parameter int unsigned TIMEOUT_NBITS = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   core_req,
  input  io_type                 core_cmd,
  output logic                   core_rdy,
  output logic                   core_rsp,
  output logic [WIDTH_NBITS-1:0] core_rsp_data,
  output logic                   core_rsp_err,
  output logic                   io_req,
  output io_type                 io_cmd,
  input  logic                   io_ack,
  input  logic [WIDTH_NBITS-1:0] io_ack_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;

  logic [TIMEOUT_NBITS-1:0] r_cnt;
  logic [TIMEOUT_NBITS-1:0] w_cnt_nxt;
  logic [TIMEOUT_NBITS-1:0] w_cnt_inc;

  logic                     r_core_rdy;
  logic                     r_core_rsp;
  logic [WIDTH_NBITS-1:0]   r_rsp_data;
  logic                     r_rsp_err;
  logic                     r_io_req;
  io_type                   r_io_cmd;

  logic                     w_core_rdy_nxt;
  logic                     w_core_rsp_nxt;
  logic [WIDTH_NBITS-1:0]   w_rsp_data_nxt;
  logic                     w_rsp_err_nxt;
  logic                     w_io_req_nxt;
  io_type                   w_io_cmd_nxt;

  logic                     w_accept;
  logic                     w_timeout;
  logic                     w_to_resp;
  logic                     w_pure_store;

  // core_rdy is only ever high in IDLE, so it alone qualifies acceptance
  assign w_accept     = core_req & r_core_rdy;
  assign w_cnt_inc    = r_cnt + TIMEOUT_NBITS'(1);
  // Timeout fires on the WAIT cycle whose increment reaches all-ones
  assign w_timeout    = (w_cnt_inc == {TIMEOUT_NBITS{1'b1}});
  // An ack on the timeout cycle still completes normally (err stays low)
  assign w_to_resp    = (r_state == S_WAIT) & (io_ack | w_timeout);
  assign w_pure_store = r_io_cmd.wr & ~r_io_cmd.atomic;

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_core_rdy <= 1'b0;
      r_core_rsp <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_io_req   <= 1'b0;
      r_io_cmd   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_core_rdy <= w_core_rdy_nxt;
      r_core_rsp <= w_core_rsp_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      r_io_req   <= w_io_req_nxt;
      r_io_cmd   <= w_io_cmd_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_ISSUE;
      S_ISSUE:                w_state_nxt = S_WAIT;
      S_WAIT:  if (w_to_resp) w_state_nxt = S_RESP;
      S_RESP:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the timeout counter.
  // Outputs are computed one cycle early so they line up with the state
  // they belong to (io_req in ISSUE, core_rsp in RESP, core_rdy in IDLE).
  always_comb begin
    w_core_rdy_nxt = 1'b0;
    w_core_rsp_nxt = 1'b0;
    w_rsp_data_nxt = '0;
    w_rsp_err_nxt  = 1'b0;
    w_io_req_nxt   = 1'b0;
    w_io_cmd_nxt   = r_io_cmd;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_core_rdy_nxt = ~w_accept;
        if (w_accept) begin
          w_io_req_nxt = 1'b1;
          w_io_cmd_nxt = core_cmd;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt = '0;
      end
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_to_resp) begin
          w_core_rsp_nxt = 1'b1;
          if (io_ack) begin
            w_rsp_data_nxt = w_pure_store ? '0 : io_ack_data;
          end else begin
            w_rsp_err_nxt = 1'b1;
          end
        end
      end
      S_RESP: begin
        w_core_rdy_nxt = 1'b1;
      end
      default: begin
        w_core_rdy_nxt = 1'b0;
      end
    endcase
  end

  assign core_rdy      = r_core_rdy;
  assign core_rsp      = r_core_rsp;
  assign core_rsp_data = r_rsp_data;
  assign core_rsp_err  = r_rsp_err;
  assign io_req        = r_io_req;
  assign io_cmd        = r_io_cmd;

endmodule

// File: tb/tb_pu_io_initiator.sv
// Directed bench for pu_io_initiator with a 4-bit ack timeout (15 WAIT cycles).
module tb_pu_io_initiator;
  import pu_io_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned TN = 4;

  logic           clk;
  logic           rstn;
  logic           core_req;
  io_type         core_cmd;
  logic           core_rdy;
  logic           core_rsp;
  logic [W-1:0]   core_rsp_data;
  logic           core_rsp_err;
  logic           io_req;
  io_type         io_cmd;
  logic           io_ack;
  logic [W-1:0]   io_ack_data;

  int n_chk  = 0;
  int n_pass = 0;

  pu_io_initiator #(
    .WIDTH_NBITS  (W),
    .TIMEOUT_NBITS(TN)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .core_req     (core_req),
    .core_cmd     (core_cmd),
    .core_rdy     (core_rdy),
    .core_rsp     (core_rsp),
    .core_rsp_data(core_rsp_data),
    .core_rsp_err (core_rsp_err),
    .io_req       (io_req),
    .io_cmd       (io_cmd),
    .io_ack       (io_ack),
    .io_ack_data  (io_ack_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic io_type mk_cmd(input logic [31:0] addr, input logic [7:0] tid,
                                    input logic wr, input logic atomic,
                                    input logic [4:0] f5, input logic [31:0] wdata);
    io_type c;
    c        = '0;
    c.addr   = addr;
    c.tid    = tid;
    c.wr     = wr;
    c.atomic = atomic;
    c.funct5 = f5;
    c.wdata  = wdata;
    return c;
  endfunction

  // Issue one access from an IDLE negedge. ack_dly = negedges after the io_req
  // cycle at which io_ack is driven (0 = never). exp_cyc = negedge on which
  // core_rsp is expected, counted the same way.
  task automatic run_access(input string tag, input io_type cmd, input int ack_dly,
                            input logic [31:0] ack_d, input int exp_cyc,
                            input logic [31:0] exp_d, input logic exp_err);
    int   cyc;
    int   extra_req;
    logic seen;
    logic rdy_hi;
    chk({tag, "_rdy_pre"}, 96'(core_rdy), 96'(1));
    core_req = 1'b1;
    core_cmd = cmd;
    @(negedge clk);
    chk({tag, "_io_req"}, 96'(io_req), 96'(1));
    chk({tag, "_io_cmd"}, 96'(io_cmd), 96'(cmd));
    chk({tag, "_rdy_busy"}, 96'(core_rdy), 96'(0));
    core_req  = 1'b0;
    core_cmd  = '0;
    cyc       = 0;
    extra_req = 0;
    seen      = 1'b0;
    rdy_hi    = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      io_ack = 1'b0;
      if (core_rdy) rdy_hi = 1'b1;
      if (io_req)   extra_req++;
      if (core_rsp) seen = 1'b1;
      else if (ack_dly > 0 && cyc == ack_dly) begin
        io_ack      = 1'b1;
        io_ack_data = ack_d;
      end
    end
    chk({tag, "_rsp_seen"}, 96'(seen), 96'(1));
    chk({tag, "_latency"}, 96'(cyc), 96'(exp_cyc));
    chk({tag, "_rsp_data"}, 96'(core_rsp_data), 96'(exp_d));
    chk({tag, "_rsp_err"}, 96'(core_rsp_err), 96'(exp_err));
    chk({tag, "_rdy_low_wait"}, 96'(rdy_hi), 96'(0));
    chk({tag, "_single_io_req"}, 96'(extra_req), 96'(0));
    chk({tag, "_io_cmd_held"}, 96'(io_cmd), 96'(cmd));
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 96'(core_rsp), 96'(0));
    chk({tag, "_data_idle"}, 96'(core_rsp_data), 96'(0));
    chk({tag, "_err_idle"}, 96'(core_rsp_err), 96'(0));
    chk({tag, "_rdy_back"}, 96'(core_rdy), 96'(1));
  endtask

  logic any_rsp;

  initial begin
    rstn        = 1'b0;
    core_req    = 1'b0;
    core_cmd    = '0;
    io_ack      = 1'b0;
    io_ack_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rdy", 96'(core_rdy), 96'(0));
    chk("rst_rsp", 96'(core_rsp), 96'(0));
    chk("rst_data", 96'(core_rsp_data), 96'(0));
    chk("rst_err", 96'(core_rsp_err), 96'(0));
    chk("rst_io_req", 96'(io_req), 96'(0));
    chk("rst_io_cmd", 96'(io_cmd), 96'(0));
    rstn = 1'b1;
    @(negedge clk);
    chk("rdy_first_clk", 96'(core_rdy), 96'(1));

    // Load, ack 4 cycles after io_req
    run_access("load", mk_cmd(32'h10, 8'd3, 1'b0, 1'b0, 5'd0, 32'h0),
               4, 32'hDEADBEEF, 5, 32'hDEADBEEF, 1'b0);
    // Pure store: ack data must not reach the core
    run_access("store", mk_cmd(32'h20, 8'd1, 1'b1, 1'b0, 5'd0, 32'h55),
               2, 32'h1234, 3, 32'h0, 1'b0);
    // Atomic returns the old value
    run_access("amo_ack", mk_cmd(32'h30, 8'd2, 1'b1, 1'b1, 5'd0, 32'h3),
               1, 32'h99, 2, 32'h99, 1'b0);
    // Atomic with no ack: timeout 15 cycles after WAIT entry
    run_access("amo_to", mk_cmd(32'h40, 8'd4, 1'b1, 1'b1, 5'd0, 32'h1),
               0, 32'h0, 16, 32'h0, 1'b1);
    // Late ack after the timeout is ignored
    io_ack      = 1'b1;
    io_ack_data = 32'h5;
    any_rsp     = 1'b0;
    @(negedge clk);
    io_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (core_rsp) any_rsp = 1'b1;
      @(negedge clk);
    end
    chk("late_ack_no_rsp", 96'(any_rsp), 96'(0));
    chk("late_ack_rdy", 96'(core_rdy), 96'(1));

    // Ack one cycle before and exactly on the timeout cycle
    run_access("ack_pre_to", mk_cmd(32'h50, 8'd5, 1'b0, 1'b0, 5'd0, 32'h0),
               14, 32'h8, 15, 32'h8, 1'b0);
    run_access("ack_on_to", mk_cmd(32'h54, 8'd6, 1'b0, 1'b0, 5'd0, 32'h0),
               15, 32'h7, 16, 32'h7, 1'b0);

    // Stray ack while IDLE
    io_ack      = 1'b1;
    io_ack_data = 32'hBB;
    @(negedge clk);
    io_ack = 1'b0;
    chk("stray_no_rsp", 96'(core_rsp), 96'(0));
    chk("stray_rdy", 96'(core_rdy), 96'(1));
    @(negedge clk);
    chk("stray_no_rsp2", 96'(core_rsp), 96'(0));
    run_access("after_stray", mk_cmd(32'h60, 8'd7, 1'b0, 1'b0, 5'd0, 32'h0),
               3, 32'hA, 4, 32'hA, 1'b0);

    // Reset in the middle of WAIT
    core_req = 1'b1;
    core_cmd = mk_cmd(32'h70, 8'd9, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 96'(core_rdy), 96'(0));
    chk("mid_rst_rsp", 96'(core_rsp), 96'(0));
    chk("mid_rst_data", 96'(core_rsp_data), 96'(0));
    chk("mid_rst_err", 96'(core_rsp_err), 96'(0));
    chk("mid_rst_io_req", 96'(io_req), 96'(0));
    chk("mid_rst_io_cmd", 96'(io_cmd), 96'(0));
    @(negedge clk);
    io_ack      = 1'b1;
    io_ack_data = 32'hEE;
    rstn        = 1'b1;
    @(negedge clk);
    io_ack = 1'b0;
    chk("post_rst_no_rsp", 96'(core_rsp), 96'(0));
    chk("post_rst_rdy", 96'(core_rdy), 96'(1));
    @(negedge clk);
    chk("post_rst_no_rsp2", 96'(core_rsp), 96'(0));
    run_access("post_rst", mk_cmd(32'h80, 8'd10, 1'b0, 1'b0, 5'd0, 32'h0),
               2, 32'h77, 3, 32'h77, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pu_io_initiator.md
PU_IO_INITIATOR -- requirements
Module: pu_io_initiator

Interface
REQ-001 Parameter WIDTH_NBITS, default `PU_WIDTH_NBITS, data width of wdata/rdata.
REQ-002 Parameter TIMEOUT_NBITS, default 8, width of the ack-timeout counter; timeout = 2**TIMEOUT_NBITS-1 cycles.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low (the codebase `RESET_SIG).
REQ-005 core_req  input  1  core access request; qualified by core_rdy.
REQ-006 core_cmd  input  io_type  access descriptor: addr, tid, wr, atomic, funct5, wdata.
REQ-007 core_rdy  output  1  block accepts core_req this cycle.
REQ-008 core_rsp  output  1  one-cycle response strobe.
REQ-009 core_rsp_data  output  WIDTH_NBITS  read/old-value data; valid with core_rsp.
REQ-010 core_rsp_err  output  1  response ended by timeout; valid with core_rsp.
REQ-011 io_req  output  1  one-cycle request pulse to memory responder.
REQ-012 io_cmd  output  io_type  command; stable from io_req until the next accepted core_req.
REQ-013 io_ack  input  1  one-cycle completion strobe from responder.
REQ-014 io_ack_data  input  WIDTH_NBITS  responder data, valid with io_ack.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; exactly one access outstanding.
REQ-016 core_rdy = 1 only in IDLE; core_req&core_rdy registers core_cmd into io_cmd and moves to ISSUE.
REQ-017 ISSUE: io_req=1 for exactly one cycle, timeout counter cleared, next state WAIT.
REQ-018 WAIT: counter increments each cycle; io_ack moves to RESP, capturing io_ack_data.
REQ-019 WAIT: counter reaching 2**TIMEOUT_NBITS-1 without io_ack moves to RESP with err set, data 0.
REQ-020 io_ack and timeout in the same cycle: io_ack wins, err=0.
REQ-021 RESP: core_rsp=1 for one cycle; next state IDLE; core_rdy returns the following cycle.
REQ-022 Pure store (wr=1, atomic=0): core_rsp_data=0 regardless of io_ack_data; response still required.
REQ-023 Load (wr=0) and atomic (atomic=1): core_rsp_data = io_ack_data (pre-modification value for atomics).
REQ-024 io_ack in IDLE, ISSUE or RESP (late/stray ack) is ignored: no state change, no response.
REQ-025 core_rsp_data and core_rsp_err are 0 whenever core_rsp=0.
REQ-026 Minimum core_req to core_rsp latency: 3 cycles after acceptance plus responder latency; back-to-back throughput one access per (ack latency + 3) cycles.
REQ-027 io_cmd fields passed unmodified; the block does not decode addr or funct5.

Reset
REQ-028 rstn low asynchronously forces IDLE; io_req=0, core_rsp=0, core_rsp_data=0, core_rsp_err=0, counter=0, io_cmd=0.
REQ-029 After rstn deasserts, core_rdy=1 on the first clock.
REQ-030 Reset during WAIT abandons the access; a subsequent io_ack is ignored per REQ-024.

Verification
REQ-031 Load addr 0x10, tid 3; responder acks 4 cycles after io_req with 0xDEADBEEF -> one io_req pulse, io_cmd matches, core_rsp one cycle with data 0xDEADBEEF, err=0.
REQ-032 Store wdata 0x55; ack with io_ack_data 0x1234 -> core_rsp with data 0, err=0; core_rdy low from accept to the cycle after core_rsp.
REQ-033 Atomic add (funct5=0) with no io_ack, TIMEOUT_NBITS=4 -> core_rsp 15 cycles after entering WAIT, err=1, data 0; later ack produces no response.
REQ-034 io_ack on the exact timeout cycle with data 0x7 -> core_rsp err=0, data 0x7.
REQ-035 Stray io_ack while IDLE, then load with ack data 0xA -> only one core_rsp, data 0xA.
REQ-036 rstn asserted mid-WAIT, released, new load issued -> old access dropped, all outputs 0 during reset, new access completes normally.
